// File: rtl/spimem_arb.sv
// rtl/spimem_arb.sv - two-port read arbiter sharing one spimemio valid/ready port
module spimem_arb #(
  parameter bit ROUND_ROBIN = 1'b1
) (
  input  logic        clk,
  input  logic        reset_l,
  input  logic        p0_rd_req,
  input  logic [23:0] p0_addr,
  output logic        p0_rd_ack,
  output logic [31:0] p0_rd_data,
  input  logic        p1_rd_req,
  input  logic [23:0] p1_addr,
  output logic        p1_rd_ack,
  output logic [31:0] p1_rd_data,
  output logic        spimem_valid,
  output logic [23:0] spimem_addr,
  input  logic [31:0] spimem_rdata,
  input  logic        spimem_ready,
  output logic [1:0]  overrun
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state;
  state_t      state_next;
  logic        pend0;
  logic        pend1;
  logic [23:0] addr0;
  logic [23:0] addr1;
  logic        owner;
  logic        last_grant;
  logic        grant;
  logic        grant_port;
  logic        complete;
  logic        inflight0;
  logic        inflight1;
  logic        accept0;
  logic        accept1;

  // A port stops being in flight at the edge where its completion is sampled,
  // so a request arriving on that same edge is accepted.
  always_comb begin
    inflight0 = (state == BUSY) && (owner == 1'b0) && !spimem_ready;
    inflight1 = (state == BUSY) && (owner == 1'b1) && !spimem_ready;
    accept0   = p0_rd_req && !pend0 && !inflight0;
    accept1   = p1_rd_req && !pend1 && !inflight1;
  end

  // State register.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and arbitration decision.
  always_comb begin
    state_next = state;
    grant      = 1'b0;
    grant_port = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (pend0 || pend1) begin
          grant      = 1'b1;
          state_next = BUSY;
          if (pend0 && pend1) begin
            grant_port = ROUND_ROBIN ? ~last_grant : 1'b0;
          end else begin
            grant_port = pend1;
          end
        end
      end
      BUSY: begin
        if (spimem_ready) begin
          complete   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Per-port pending latches, address registers and sticky overrun flags.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      pend0   <= 1'b0;
      pend1   <= 1'b0;
      addr0   <= '0;
      addr1   <= '0;
      overrun <= 2'b00;
    end else begin
      if (accept0) begin
        pend0 <= 1'b1;
        addr0 <= p0_addr;
      end else if (grant && !grant_port) begin
        pend0 <= 1'b0;
      end
      if (accept1) begin
        pend1 <= 1'b1;
        addr1 <= p1_addr;
      end else if (grant && grant_port) begin
        pend1 <= 1'b0;
      end
      if (p0_rd_req && !accept0) begin
        overrun[0] <= 1'b1;
      end
      if (p1_rd_req && !accept1) begin
        overrun[1] <= 1'b1;
      end
    end
  end

  // spimemio request, ownership tracking and per-port completion.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      spimem_valid <= 1'b0;
      spimem_addr  <= '0;
      owner        <= 1'b0;
      last_grant   <= 1'b1;
      p0_rd_ack    <= 1'b0;
      p1_rd_ack    <= 1'b0;
      p0_rd_data   <= '0;
      p1_rd_data   <= '0;
    end else begin
      p0_rd_ack <= 1'b0;
      p1_rd_ack <= 1'b0;
      if (grant) begin
        spimem_valid <= 1'b1;
        spimem_addr  <= grant_port ? addr1 : addr0;
        owner        <= grant_port;
        last_grant   <= grant_port;
      end
      if (complete) begin
        spimem_valid <= 1'b0;
        if (owner) begin
          p1_rd_ack  <= 1'b1;
          p1_rd_data <= spimem_rdata;
        end else begin
          p0_rd_ack  <= 1'b1;
          p0_rd_data <= spimem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_spimem_arb.sv
// tb/tb_spimem_arb.sv - scoreboard bench for spimem_arb, round-robin and fixed-priority instances
module tb_spimem_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_l      [2];
  logic        p0_rd_req    [2];
  logic [23:0] p0_addr      [2];
  logic        p0_rd_ack    [2];
  logic [31:0] p0_rd_data   [2];
  logic        p1_rd_req    [2];
  logic [23:0] p1_addr      [2];
  logic        p1_rd_ack    [2];
  logic [31:0] p1_rd_data   [2];
  logic        spimem_valid [2];
  logic [23:0] spimem_addr  [2];
  logic [31:0] spimem_rdata [2];
  logic        spimem_ready [2];
  logic [1:0]  overrun      [2];
  int          stub_cnt     [2];

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q00 [$];
  logic [31:0] exp_q01 [$];
  logic [31:0] exp_q10 [$];
  logic [31:0] exp_q11 [$];
  int          ack_log0 [$];
  int          ack_log1 [$];
  int          exp_ord [$];
  bit          prev_ack [2][2];

  // instance 0 alternates on contention, instance 1 always favours port 0
  for (genvar i = 0; i < 2; i++) begin : g_inst
    spimem_arb #(.ROUND_ROBIN(i == 0)) dut (
      .clk          (clk),
      .reset_l      (reset_l[i]),
      .p0_rd_req    (p0_rd_req[i]),
      .p0_addr      (p0_addr[i]),
      .p0_rd_ack    (p0_rd_ack[i]),
      .p0_rd_data   (p0_rd_data[i]),
      .p1_rd_req    (p1_rd_req[i]),
      .p1_addr      (p1_addr[i]),
      .p1_rd_ack    (p1_rd_ack[i]),
      .p1_rd_data   (p1_rd_data[i]),
      .spimem_valid (spimem_valid[i]),
      .spimem_addr  (spimem_addr[i]),
      .spimem_rdata (spimem_rdata[i]),
      .spimem_ready (spimem_ready[i]),
      .overrun      (overrun[i])
    );
  end

  // spimemio stub: ready pulse a fixed number of cycles after valid, data = {A5, addr}
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset_l[i]) begin
        spimem_ready[i] <= 1'b0;
        spimem_rdata[i] <= '0;
        stub_cnt[i]     <= 0;
      end else if (spimem_valid[i] && !spimem_ready[i]) begin
        if (stub_cnt[i] == 3) begin
          spimem_ready[i] <= 1'b1;
          spimem_rdata[i] <= {8'hA5, spimem_addr[i]};
          stub_cnt[i]     <= 0;
        end else begin
          stub_cnt[i] <= stub_cnt[i] + 1;
        end
      end else begin
        spimem_ready[i] <= 1'b0;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int k, input int p, input logic [23:0] a);
    logic [31:0] d;
    d = {8'hA5, a};
    case (k * 2 + p)
      0: exp_q00.push_back(d);
      1: exp_q01.push_back(d);
      2: exp_q10.push_back(d);
      default: exp_q11.push_back(d);
    endcase
  endtask

  function automatic bit exp_empty(input int k);
    if (k == 0) return (exp_q00.size() == 0) && (exp_q01.size() == 0);
    return (exp_q10.size() == 0) && (exp_q11.size() == 0);
  endfunction

  task automatic consume(input int k, input int p, input logic [31:0] data);
    logic [31:0] e;
    bit          have;
    have = 1'b0;
    e    = '0;
    case (k * 2 + p)
      0: if (exp_q00.size() > 0) begin e = exp_q00.pop_front(); have = 1'b1; end
      1: if (exp_q01.size() > 0) begin e = exp_q01.pop_front(); have = 1'b1; end
      2: if (exp_q10.size() > 0) begin e = exp_q10.pop_front(); have = 1'b1; end
      default: if (exp_q11.size() > 0) begin e = exp_q11.pop_front(); have = 1'b1; end
    endcase
    check_eq($sformatf("ack_expected_i%0d_p%0d", k, p), {63'd0, have}, 64'd1);
    if (have) check_eq($sformatf("rd_data_i%0d_p%0d", k, p), data, e);
    if (k == 0) ack_log0.push_back(p);
    else ack_log1.push_back(p);
  endtask

  // Scoreboard side: every ack pops the expected word for that port.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 2; p++) begin
        logic        a;
        logic [31:0] d;
        a = p ? p1_rd_ack[k] : p0_rd_ack[k];
        d = p ? p1_rd_data[k] : p0_rd_data[k];
        if (a === 1'b1) begin
          check_eq($sformatf("ack_single_cycle_i%0d_p%0d", k, p), {63'd0, prev_ack[k][p]}, 64'd0);
          consume(k, p, d);
        end
        prev_ack[k][p] <= (a === 1'b1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs(input int k);
    p0_rd_req[k] = 1'b0;
    p1_rd_req[k] = 1'b0;
  endtask

  task automatic apply_reset(input int k);
    clear_reqs(k);
    reset_l[k] = 1'b0;
    tick();
    tick();
    reset_l[k] = 1'b1;
    tick();
  endtask

  task automatic drain(input int k);
    int n;
    n = 0;
    while ((!exp_empty(k) || spimem_valid[k]) && n < 200) begin
      tick();
      n++;
    end
    check_eq($sformatf("drain_in_time_i%0d", k), {63'd0, (n < 200)}, 64'd1);
    repeat (15) tick();
  endtask

  task automatic wait_valid(input int k);
    int n;
    n = 0;
    while (!spimem_valid[k] && n < 50) begin
      tick();
      n++;
    end
    check_eq($sformatf("valid_rose_i%0d", k), {63'd0, spimem_valid[k]}, 64'd1);
  endtask

  task automatic check_order(input int k, input string tag);
    int lg [$];
    if (k == 0) lg = ack_log0;
    else lg = ack_log1;
    check_eq({tag, "_count"}, lg.size(), exp_ord.size());
    for (int i = 0; i < lg.size() && i < exp_ord.size(); i++) begin
      check_eq($sformatf("%s_grant%0d", tag, i), lg[i], exp_ord[i]);
    end
  endtask

  task automatic check_reset_values(input int k, input string tag);
    check_eq({tag, "_valid"}, spimem_valid[k], 0);
    check_eq({tag, "_addr"}, spimem_addr[k], 0);
    check_eq({tag, "_p0_ack"}, p0_rd_ack[k], 0);
    check_eq({tag, "_p1_ack"}, p1_rd_ack[k], 0);
    check_eq({tag, "_p0_data"}, p0_rd_data[k], 0);
    check_eq({tag, "_p1_data"}, p1_rd_data[k], 0);
    check_eq({tag, "_overrun"}, overrun[k], 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    bit hist [24];
    int fall_at;
    int gap;
    int a0;
    int a1;
    int n;
    int served;
    int n_txn;

    for (int k = 0; k < 2; k++) begin
      reset_l[k] = 1'b0;
      clear_reqs(k);
      p0_addr[k] = '0;
      p1_addr[k] = '0;
    end
    repeat (3) tick();
    check_reset_values(0, "reset_i0");
    check_reset_values(1, "reset_i1");
    reset_l[0] = 1'b1;
    reset_l[1] = 1'b1;
    tick();

    // single port-0 read
    p0_rd_req[0] = 1'b1;
    p0_addr[0]   = 24'h000108;
    push_exp(0, 0, 24'h000108);
    tick();
    p0_rd_req[0] = 1'b0;
    check_eq("single_valid_after_E", spimem_valid[0], 0);
    tick();
    check_eq("single_valid_after_E1", spimem_valid[0], 1);
    check_eq("single_addr", spimem_addr[0], 24'h000108);
    drain(0);

    // simultaneous requests, port 0 first, one idle cycle between transfers
    apply_reset(0);
    ack_log0.delete();
    p0_rd_req[0] = 1'b1;
    p0_addr[0]   = 24'h00011C;
    p1_rd_req[0] = 1'b1;
    p1_addr[0]   = 24'h000200;
    push_exp(0, 0, 24'h00011C);
    push_exp(0, 1, 24'h000200);
    tick();
    clear_reqs(0);
    for (int c = 0; c < 24; c++) begin
      hist[c] = spimem_valid[0];
      tick();
    end
    fall_at = -1;
    gap = 0;
    for (int c = 0; c < 23; c++) begin
      if (fall_at < 0 && hist[c] && !hist[c + 1]) fall_at = c + 1;
    end
    if (fall_at >= 0) begin
      for (int c = fall_at; c < 24 && !hist[c]; c++) gap++;
    end
    check_eq("simul_idle_gap", gap, 1);
    drain(0);
    exp_ord.delete();
    exp_ord.push_back(0);
    exp_ord.push_back(1);
    check_order(0, "simul");

    // fairness: the served port re-requests on the edge its completion is sampled
    for (int k = 0; k < 2; k++) begin
      apply_reset(k);
      if (k == 0) ack_log0.delete();
      else ack_log1.delete();
      exp_ord.delete();
      n_txn = (k == 0) ? 6 : 7;
      for (int t = 0; t < n_txn; t++) begin
        if (k == 0) exp_ord.push_back(t % 2);
        else exp_ord.push_back((t < 6) ? 0 : 1);
      end
      a0 = 24'h000400;
      a1 = 24'h000800;
      p0_rd_req[k] = 1'b1;
      p0_addr[k]   = a0[23:0];
      p1_rd_req[k] = 1'b1;
      p1_addr[k]   = a1[23:0];
      push_exp(k, 0, a0[23:0]);
      push_exp(k, 1, a1[23:0]);
      tick();
      clear_reqs(k);
      for (int t = 0; t < n_txn; t++) begin
        n = 0;
        while (!spimem_ready[k] && n < 50) begin
          tick();
          n++;
        end
        check_eq($sformatf("fair_ready_i%0d_t%0d", k, t), spimem_ready[k], 1);
        served = exp_ord[t];
        if ((k == 0) ? (t < 4) : (t < 5)) begin
          if (served == 0) begin
            a0 = a0 + 4;
            p0_rd_req[k] = 1'b1;
            p0_addr[k]   = a0[23:0];
            push_exp(k, 0, a0[23:0]);
          end else begin
            a1 = a1 + 4;
            p1_rd_req[k] = 1'b1;
            p1_addr[k]   = a1[23:0];
            push_exp(k, 1, a1[23:0]);
          end
        end
        tick();
        clear_reqs(k);
      end
      drain(k);
      check_order(k, (k == 0) ? "fair_rr" : "fair_fixed");
      check_eq($sformatf("fair_overrun_i%0d", k), overrun[k], 0);
    end

    // overrun: second port-1 request while the first is in flight is dropped
    apply_reset(0);
    ack_log0.delete();
    p1_rd_req[0] = 1'b1;
    p1_addr[0]   = 24'h000104;
    push_exp(0, 1, 24'h000104);
    tick();
    clear_reqs(0);
    wait_valid(0);
    p1_rd_req[0] = 1'b1;
    p1_addr[0]   = 24'h000124;
    tick();
    clear_reqs(0);
    drain(0);
    check_eq("overrun_flag", overrun[0], 2'b10);
    check_eq("overrun_ack_count", ack_log0.size(), 1);

    // reset two cycles into a transfer
    ack_log0.delete();
    p0_rd_req[0] = 1'b1;
    p0_addr[0]   = 24'h000104;
    tick();
    clear_reqs(0);
    wait_valid(0);
    tick();
    tick();
    #2;
    reset_l[0] = 1'b0;
    #1;
    check_reset_values(0, "midreset");
    tick();
    tick();
    reset_l[0] = 1'b1;
    repeat (15) tick();
    check_eq("midreset_no_ack", ack_log0.size(), 0);
    check_eq("midreset_valid_stays_low", spimem_valid[0], 0);
    p0_rd_req[0] = 1'b1;
    p0_addr[0]   = 24'h000104;
    push_exp(0, 0, 24'h000104);
    tick();
    clear_reqs(0);
    drain(0);
    check_eq("midreset_reissue_count", ack_log0.size(), 1);

    // a request in the ack cycle is accepted
    ack_log0.delete();
    p0_rd_req[0] = 1'b1;
    p0_addr[0]   = 24'h000108;
    push_exp(0, 0, 24'h000108);
    tick();
    clear_reqs(0);
    n = 0;
    while (!p0_rd_ack[0] && n < 50) begin
      tick();
      n++;
    end
    check_eq("overlap_first_ack", p0_rd_ack[0], 1);
    p0_rd_req[0] = 1'b1;
    p0_addr[0]   = 24'h000124;
    push_exp(0, 0, 24'h000124);
    tick();
    clear_reqs(0);
    drain(0);
    check_eq("overlap_overrun", overrun[0], 0);
    check_eq("overlap_ack_count", ack_log0.size(), 2);
    check_eq("overlap_last_data", p0_rd_data[0], 32'hA5000124);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spimem_arb.md
# spimem_arb

Two-port read arbiter that shares the single `spimemio` valid/ready read port between the instruction cache and a second read client (data/DMA). Each client uses the pulse-style `rd_req`/`rd_ack` protocol that the `icache` client side uses. The arbiter latches requests, selects a winner (round-robin or fixed priority), and holds `spimem_valid`/`spimem_addr` stable until `spimem_ready`. It then returns the word to the winning port.

## Interface

Parameters:
- `ROUND_ROBIN`, default 1: 1 = alternate on contention; 0 = port 0 always wins.

Ports:
- `clk`  in  1  sole clock; all logic is on the rising edge.
- `reset_l`  in  1  asynchronous active-low reset.
- `p0_rd_req`  in  1  one-cycle request pulse from port 0 (icache).
- `p0_addr`  in  24  byte address; sampled only when `p0_rd_req`=1.
- `p0_rd_ack`  out  1  one-cycle completion pulse.
- `p0_rd_data`  out  32  read word; valid with `p0_rd_ack`, held until the next port-0 ack.
- `p1_rd_req`, `p1_addr`, `p1_rd_ack`, `p1_rd_data`: same as port 0, for port 1.
- `spimem_valid`  out  1  request to `spimemio`; held high until `spimem_ready`.
- `spimem_addr`  out  24  address to `spimemio`; stable while `spimem_valid`=1.
- `spimem_rdata`  in  32  data from `spimemio`; valid when `spimem_ready`=1.
- `spimem_ready`  in  1  transfer complete (single-cycle pulse from `spimemio`).
- `overrun`  out  2  sticky per-port flag: a request was dropped; cleared only by reset.

## Operation

- **Per-port pending latch** `pendN` plus address register `addrN`.
  - `pN_rd_req`=1 while `pendN`=0 and port N is not in flight: set `pendN` and load `addrN`.
  - `pN_rd_req`=1 while `pendN`=1 or port N is in flight: drop the request, leave `addrN` unchanged, set `overrun[N]`.
  - Exception: a request in the same cycle that port N's ack is generated is accepted, because ownership ends at that edge.
- **FSM states:** IDLE, BUSY.
  - IDLE, no pending: stay in IDLE, `spimem_valid`=0.
  - IDLE, one pending: grant that port.
  - IDLE, both pending, `ROUND_ROBIN`=1: grant the port other than `last_grant`.
  - IDLE, both pending, `ROUND_ROBIN`=0: grant port 0.
  - On grant: go to BUSY, `spimem_valid`←1, `spimem_addr`←`addrG`, clear `pendG`, `owner`←G, `last_grant`←G.
  - BUSY, `spimem_ready`=0: hold `spimem_valid` and `spimem_addr` unchanged.
  - BUSY, `spimem_ready`=1: `spimem_valid`←0, `pG_rd_data`←`spimem_rdata`, `pG_rd_ack`←1 for one cycle, go to IDLE.
- An IDLE state is always inserted between transfers, so `spimem_valid` is low for at least one cycle between reads (`spimemio` handshake requirement).
- `spimem_ready` while IDLE is ignored and has no effect.
- Addresses pass through unmodified; no alignment check is made (the clients issue word-aligned addresses).

## Timing

- **Reset values (asynchronous):**
  - `spimem_valid`=0, `spimem_addr`=0.
  - `p0_rd_ack`=`p1_rd_ack`=0, `p0_rd_data`=`p1_rd_data`=0, `overrun`=0.
  - `pend0`=`pend1`=0, state=IDLE, `last_grant`=1, so port 0 wins the first contention.
- Request sampled at edge E (arbiter idle, no contention): `spimem_valid` rises after edge E+1.
- `spimem_ready` sampled high at edge R:
  - `spimem_valid` falls and `pG_rd_ack`/`pG_rd_data` are valid after edge R.
  - The ack lasts exactly one cycle.
- Next grant, if pending: `spimem_valid` high after edge R+1. Back-to-back throughput is one read per (`spimemio` latency + 2) cycles.
- Reset asserted mid-transfer:
  - All state clears immediately and `spimem_valid` drops asynchronously.
  - Pending and in-flight requests are lost; no ack is issued. Clients reissue after reset.
- Both ports requesting in the same cycle: both are latched; the winner is decided at the next edge per the arbitration rule above.

## Test plan

Bench uses a `spimemio` stub that raises `ready` 4 cycles after `valid` and returns `rdata` = {8'hA5, addr}.

- **Single port-0 read:** `p0_rd_req` pulse with `p0_addr`=24'h000108.
  - `spimem_valid` high after E+1 with `spimem_addr`=24'h000108.
  - One `p0_rd_ack` pulse with `p0_rd_data`=32'hA5000108; `p1_rd_ack` never asserts.
- **Simultaneous requests, `ROUND_ROBIN`=1:** `p0_addr`=24'h00011C, `p1_addr`=24'h000200.
  - Port 0 is served first, then port 1 (data 32'hA5000200).
  - `spimem_valid` is low for exactly one cycle between the two transfers.
- **Fairness:** both ports re-request immediately on each ack for 6 transactions.
  - `ROUND_ROBIN`=1: grants alternate 0,1,0,1,0,1.
  - `ROUND_ROBIN`=0: port 0 is granted every time; port 1 stays pending until port 0 stops requesting.
- **Overrun:** `p1_rd_req` with 24'h000104, then a second `p1_rd_req` with 24'h000124 while the first is in flight.
  - `overrun`=2'b10.
  - Exactly one `p1_rd_ack`, with data 32'hA5000104.
- **Reset mid-transfer:** `reset_l` low 2 cycles after `spimem_valid` rises.
  - `spimem_valid`=0 immediately; no ack; all outputs at reset values.
  - A subsequent request with 24'h000104 completes normally.
- **Ack/request overlap:** `p0_rd_req` with 24'h000124 issued in the cycle `p0_rd_ack` is high.
  - The request is accepted with no overrun.
  - The second ack returns 32'hA5000124.
